// File: rtl/m14k_dcc_spram_ctl_if.sv
// Core-side load/store request and response bus of the M14K DSPRAM controller.
interface m14k_dcc_spram_ctl_if;
    logic        req_valid;
    logic        req_wr;
    logic [29:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        sp_hit;
    logic        sp_stall;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output req_valid, req_wr, req_addr, req_wmask, req_wdata,
        input  sp_hit, sp_stall, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wmask, req_wdata,
        output sp_hit, sp_stall, rd_valid, rd_data
    );
endinterface

// File: rtl/m14k_dcc_spram_ctl.sv
// M14K data-scratchpad controller: window decode, DSPRAM strobes, wait states, load return.
// Optional byte parity generation/checking is enabled with `define M14K_DSPRAM_PARITY_EN.
module m14k_dcc_spram_ctl #(
    parameter int          DSP_SIZE_LOG2 = 16,
    parameter int          WAIT_STATES   = 0,
    parameter logic [31:0] BASE_RESET    = 32'h0
) (
    input  logic                 gclk,
    input  logic                 greset_n,
    input  logic                 cfg_wr,
    input  logic [31:0]          cfg_base,
    m14k_dcc_spram_ctl_if.slave  bus,
    output logic [17:0]          DSP_DataAddr,
    output logic                 DSP_DataRdStr,
    output logic                 DSP_DataWrStr,
    output logic [3:0]           DSP_DataWrMask,
    output logic [31:0]          DSP_DataWrValue,
    input  logic [31:0]          DSP_DataRdValue,
    input  logic                 DSP_Stall,
`ifdef M14K_DSPRAM_PARITY_EN
    input  logic                 cpz_pe,
    input  logic [3:0]           DSP_RPar,
    output logic [3:0]           DSP_WPar,
    output logic                 DSP_ParityEn,
    output logic                 par_err,
`endif
    output logic [8:0]           dsp_size
);

    localparam int         OFF_W     = DSP_SIZE_LOG2 - 2;
    localparam logic [1:0] WS_LOAD   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
    localparam logic [8:0] SIZE_CODE = 9'd1 << (DSP_SIZE_LOG2 - 12);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [31:DSP_SIZE_LOG2] base_q, base_d;
    logic                    en_q, en_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [17:0]             addr_q, addr_d;
    logic [3:0]              wmask_q, wmask_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rd_str_q, rd_str_d;
    logic                    wr_str_q, wr_str_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    hit_s, accept_s, complete_s;
    logic                    cfg_unused_s;

`ifdef M14K_DSPRAM_PARITY_EN
    logic                    par_err_q, par_err_d;

    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Low base bits below the window size carry no information.
    assign cfg_unused_s = ^cfg_base[DSP_SIZE_LOG2-1:1];

    assign hit_s      = bus.req_valid & en_q & (bus.req_addr[29:OFF_W] == base_q);
    assign accept_s   = hit_s & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign complete_s = ~DSP_Stall &
                        (((state_q == ST_ACCESS) & (WAIT_STATES == 0)) |
                         ((state_q == ST_WAIT) & (cnt_q == 2'd0)));

    // Next-state, request capture, strobe and load-return logic.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wmask_d    = wmask_q;
        wdata_d    = wdata_q;
        rd_str_d   = 1'b0;
        wr_str_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (cfg_wr) begin
            base_d = cfg_base[31:DSP_SIZE_LOG2];
            en_d   = cfg_base[0];
        end else begin
            base_d = base_q;
            en_d   = en_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d  = ST_ACCESS;
                    wr_d     = bus.req_wr;
                    addr_d   = 18'(bus.req_addr[OFF_W-1:0]);
                    wmask_d  = bus.req_wr ? bus.req_wmask : 4'b0000;
                    wdata_d  = bus.req_wr ? bus.req_wdata : wdata_q;
                    rd_str_d = ~bus.req_wr;
                    wr_str_d = bus.req_wr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS_LOAD;
                end else if (complete_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                // The wait counter runs regardless of DSP_Stall; the stall only gates completion.
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if (complete_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete_s && !wr_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = DSP_DataRdValue;
        end else begin
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            state_q    <= ST_IDLE;
            base_q     <= BASE_RESET[31:DSP_SIZE_LOG2];
            en_q       <= BASE_RESET[0];
            cnt_q      <= 2'd0;
            wr_q       <= 1'b0;
            addr_q     <= 18'd0;
            wmask_q    <= 4'b0000;
            wdata_q    <= 32'd0;
            rd_str_q   <= 1'b0;
            wr_str_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wmask_q    <= wmask_d;
            wdata_q    <= wdata_d;
            rd_str_q   <= rd_str_d;
            wr_str_q   <= wr_str_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef M14K_DSPRAM_PARITY_EN
    // Parity error is flagged alongside rd_valid for the completing load.
    always_comb begin
        par_err_d = 1'b0;
        if (complete_s && !wr_q && cpz_pe) begin
            par_err_d = |(byte_parity(DSP_DataRdValue) ^ DSP_RPar);
        end else begin
            par_err_d = 1'b0;
        end
    end

    // Parity error register.
    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign DSP_WPar     = byte_parity(wdata_q);
    assign DSP_ParityEn = cpz_pe;
    assign par_err      = par_err_q;
`endif

    assign bus.sp_hit      = hit_s;
    assign bus.sp_stall    = accept_s | (state_q == ST_ACCESS) | (state_q == ST_WAIT);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign DSP_DataAddr    = addr_q;
    assign DSP_DataRdStr   = rd_str_q;
    assign DSP_DataWrStr   = wr_str_q;
    assign DSP_DataWrMask  = wmask_q;
    assign DSP_DataWrValue = wdata_q;
    assign dsp_size        = SIZE_CODE;

endmodule

// File: tb/tb_m14k_dcc_spram_ctl.sv
// Bench for m14k_dcc_spram_ctl: two instances (0 and 2 wait states) share one stimulus
// stream; the bench acts as the DSPRAM and keeps a word-level model of its contents.
module tb_m14k_dcc_spram_ctl;
    localparam int SZ  = 16;
    localparam int WS0 = 0;
    localparam int WS1 = 2;

    logic        gclk = 1'b0;
    logic        greset_n;
    logic        cfg_wr;
    logic [31:0] cfg_base;
    logic [1:0]  req_vld;
    logic        req_wr;
    logic [29:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic [31:0] ram_rdata;
    logic        ram_stall;

    logic [1:0]  o_hit, o_stall, o_rdv, o_rdstr, o_wrstr;
    logic [31:0] o_rdd  [2];
    logic [17:0] o_addr [2];
    logic [3:0]  o_mask [2];
    logic [31:0] o_wval [2];
    logic [8:0]  o_size [2];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] base_m;
    logic [31:0] last_rd [2];
    logic [31:0] mem [logic [17:0]];
    logic [31:0] cfgs [4] = '{32'h8001_0001, 32'h0003_0001, 32'hFFFF_0001, 32'h8001_0000};

    always #5 gclk = ~gclk;

    m14k_dcc_spram_ctl_if bus0 ();
    m14k_dcc_spram_ctl_if bus1 ();

    assign bus0.req_valid = req_vld[0];
    assign bus0.req_wr    = req_wr;
    assign bus0.req_addr  = req_addr;
    assign bus0.req_wmask = req_wmask;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_valid = req_vld[1];
    assign bus1.req_wr    = req_wr;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wmask = req_wmask;
    assign bus1.req_wdata = req_wdata;
    assign o_hit   = {bus1.sp_hit,   bus0.sp_hit};
    assign o_stall = {bus1.sp_stall, bus0.sp_stall};
    assign o_rdv   = {bus1.rd_valid, bus0.rd_valid};
    assign o_rdd[0] = bus0.rd_data;
    assign o_rdd[1] = bus1.rd_data;

`ifdef M14K_DSPRAM_PARITY_EN
    logic [3:0] wpar0, wpar1;
    logic       pen0, pen1, perr0, perr1;
`endif

    m14k_dcc_spram_ctl #(.DSP_SIZE_LOG2(SZ), .WAIT_STATES(WS0), .BASE_RESET(32'h0)) u_dut0 (
        .gclk(gclk), .greset_n(greset_n), .cfg_wr(cfg_wr), .cfg_base(cfg_base), .bus(bus0),
        .DSP_DataAddr(o_addr[0]), .DSP_DataRdStr(o_rdstr[0]), .DSP_DataWrStr(o_wrstr[0]),
        .DSP_DataWrMask(o_mask[0]), .DSP_DataWrValue(o_wval[0]), .DSP_DataRdValue(ram_rdata),
        .DSP_Stall(ram_stall),
`ifdef M14K_DSPRAM_PARITY_EN
        .cpz_pe(1'b0), .DSP_RPar(4'b0000), .DSP_WPar(wpar0), .DSP_ParityEn(pen0), .par_err(perr0),
`endif
        .dsp_size(o_size[0])
    );

    m14k_dcc_spram_ctl #(.DSP_SIZE_LOG2(SZ), .WAIT_STATES(WS1), .BASE_RESET(32'h0)) u_dut1 (
        .gclk(gclk), .greset_n(greset_n), .cfg_wr(cfg_wr), .cfg_base(cfg_base), .bus(bus1),
        .DSP_DataAddr(o_addr[1]), .DSP_DataRdStr(o_rdstr[1]), .DSP_DataWrStr(o_wrstr[1]),
        .DSP_DataWrMask(o_mask[1]), .DSP_DataWrValue(o_wval[1]), .DSP_DataRdValue(ram_rdata),
        .DSP_Stall(ram_stall),
`ifdef M14K_DSPRAM_PARITY_EN
        .cpz_pe(1'b0), .DSP_RPar(4'b0000), .DSP_WPar(wpar1), .DSP_ParityEn(pen1), .par_err(perr1),
`endif
        .dsp_size(o_size[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    function automatic bit model_hit(input logic [29:0] a);
        return base_m[0] && (({a, 2'b00} >> SZ) == (base_m >> SZ));
    endfunction

    function automatic logic [17:0] ram_word(input logic [29:0] a);
        return 18'(a & ((30'd1 << (SZ - 2)) - 30'd1));
    endfunction

    function automatic logic [31:0] rd_mem(input logic [17:0] k);
        return mem.exists(k) ? mem[k] : {14'h0, k};
    endfunction

    task automatic mem_wr(input logic [17:0] k, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] w;
        w = rd_mem(k);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem[k] = w;
    endtask

    task automatic write_cfg(input logic [31:0] v);
        @(negedge gclk);
        cfg_wr   = 1'b1;
        cfg_base = v;
        @(negedge gclk);
        cfg_wr = 1'b0;
        base_m = v;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_rdstr%0d", tag, i), 32'(o_rdstr[i]), 32'd0);
            chk($sformatf("%s_wrstr%0d", tag, i), 32'(o_wrstr[i]), 32'd0);
            chk($sformatf("%s_stall%0d", tag, i), 32'(o_stall[i]), 32'd0);
            chk($sformatf("%s_rdv%0d", tag, i), 32'(o_rdv[i]), 32'd0);
            chk($sformatf("%s_mask%0d", tag, i), 32'(o_mask[i]), 32'd0);
            chk($sformatf("%s_rdd%0d", tag, i), o_rdd[i], 32'd0);
            chk($sformatf("%s_addr%0d", tag, i), 32'(o_addr[i]), 32'd0);
            chk($sformatf("%s_wval%0d", tag, i), o_wval[i], 32'd0);
            chk($sformatf("%s_size%0d", tag, i), 32'(o_size[i]), 32'h10);
        end
    endtask

    // One request followed by its whole access; stl[r] is DSP_Stall r cycles after the strobe.
    task automatic txn(input logic wr, input logic [29:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [7:0] stl_in,
                       input logic cfg_mid, input logic [31:0] cfg_new);
        bit          hit;
        int          td [2];
        int          last;
        logic [7:0]  stl;
        logic [17:0] ea;
        logic [31:0] rv;
        stl = stl_in & 8'h1F;
        hit = model_hit(a);
        ea  = ram_word(a);
        rv  = rd_mem(ea);
        @(negedge gclk);
        req_vld = 2'b11; req_wr = wr; req_addr = a; req_wmask = m; req_wdata = d;
        ram_stall = 1'b0; ram_rdata = $urandom;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("hit%0d", i), 32'(o_hit[i]), 32'(hit));
            chk($sformatf("hitstall%0d", i), 32'(o_stall[i]), 32'(hit));
        end
        if (!hit) begin
            @(negedge gclk);
            req_vld = 2'b00;
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("miss_str%0d", i), 32'({o_rdstr[i], o_wrstr[i]}), 32'd0);
                chk($sformatf("miss_stall%0d", i), 32'(o_stall[i]), 32'd0);
                chk($sformatf("miss_rdd%0d", i), o_rdd[i], last_rd[i]);
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            td[i] = ws_of(i);
            while (stl[td[i]]) td[i]++;
        end
        last = td[1] + 1;
        for (int r = 0; r <= last; r++) begin
            @(negedge gclk);
            req_vld   = 2'b00;
            ram_stall = stl[r];
            ram_rdata = (r >= td[0]) ? rv : $urandom;
            cfg_wr    = cfg_mid && (r == 1);
            cfg_base  = cfg_new;
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rdstr%0d_r%0d", i, r), 32'(o_rdstr[i]), 32'(r == 0 && !wr));
                chk($sformatf("wrstr%0d_r%0d", i, r), 32'(o_wrstr[i]), 32'(r == 0 && wr));
                chk($sformatf("stall%0d_r%0d", i, r), 32'(o_stall[i]), 32'(r <= td[i]));
                chk($sformatf("rdv%0d_r%0d", i, r), 32'(o_rdv[i]), 32'(!wr && r == td[i] + 1));
                if (r <= td[i]) chk($sformatf("addr%0d_r%0d", i, r), 32'(o_addr[i]), 32'(ea));
                if (r == 0 && wr) begin
                    chk($sformatf("wmask%0d", i), 32'(o_mask[i]), 32'(m));
                    chk($sformatf("wval%0d", i), o_wval[i], d);
                end
                if (r == td[i] + 1) chk($sformatf("rdd%0d", i), o_rdd[i], wr ? last_rd[i] : rv);
            end
        end
        ram_stall = 1'b0;
        if (cfg_mid) base_m = cfg_new;
        if (wr) mem_wr(ea, m, d);
        else begin
            last_rd[0] = rv;
            last_rd[1] = rv;
        end
    endtask

    // Load to a, then a store to b presented in each instance's DONE cycle.
    task automatic b2b(input logic [29:0] a, input logic [29:0] b, input logic [3:0] m,
                       input logic [31:0] d);
        int          dd [2];
        logic [17:0] ea, eb;
        logic [31:0] rv;
        ea = ram_word(a);
        eb = ram_word(b);
        rv = rd_mem(ea);
        dd[0] = 2 + WS0;
        dd[1] = 2 + WS1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge gclk);
            for (int i = 0; i < 2; i++) req_vld[i] = (c == 0) || (c == dd[i]);
            req_wr = (c != 0); req_addr = (c == 0) ? a : b; req_wmask = m; req_wdata = d;
            ram_stall = 1'b0;
            ram_rdata = (c >= 1) ? rv : $urandom;
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("b2b_rdstr%0d_c%0d", i, c), 32'(o_rdstr[i]), 32'(c == 1));
                chk($sformatf("b2b_wrstr%0d_c%0d", i, c), 32'(o_wrstr[i]), 32'(c == dd[i] + 1));
                chk($sformatf("b2b_rdv%0d_c%0d", i, c), 32'(o_rdv[i]), 32'(c == dd[i]));
                chk($sformatf("b2b_stall%0d_c%0d", i, c), 32'(o_stall[i]),
                    32'(c <= 3 + 2 * ws_of(i)));
                if (c == dd[i]) chk($sformatf("b2b_rdd%0d", i), o_rdd[i], rv);
                if (c == dd[i] + 1) begin
                    chk($sformatf("b2b_addr%0d", i), 32'(o_addr[i]), 32'(eb));
                    chk($sformatf("b2b_mask%0d", i), 32'(o_mask[i]), 32'(m));
                    chk($sformatf("b2b_wval%0d", i), o_wval[i], d);
                end
            end
        end
        req_vld = 2'b00;
        last_rd[0] = rv;
        last_rd[1] = rv;
        mem_wr(eb, m, d);
    endtask

    initial begin
        logic [29:0] a;
        logic [29:0] wmsk;
        greset_n = 1'b0; cfg_wr = 1'b0; cfg_base = 32'h0; req_vld = 2'b00; req_wr = 1'b0;
        req_addr = 30'h0; req_wmask = 4'h0; req_wdata = 32'h0; ram_rdata = 32'h0; ram_stall = 1'b0;
        base_m = 32'h0; last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        wmsk = (30'd1 << (SZ - 2)) - 30'd1;
        repeat (2) @(negedge gclk);
        #1;
        chk_all_zero("rst");
        @(negedge gclk);
        greset_n = 1'b1;
        #1;
        chk_all_zero("post_rst");

        write_cfg(32'h8001_0001);
        mem[18'h10] = 32'hDEAD_BEEF;
        txn(1'b0, 30'h2000_4010, 4'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        txn(1'b0, 30'h2000_8000, 4'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        txn(1'b1, 30'h2000_4020, 4'b0110, 32'h1234_5678, 8'h00, 1'b0, 32'h0);
        txn(1'b0, 30'h2000_4020, 4'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        txn(1'b0, 30'h2000_4010, 4'h0, 32'h0, 8'b0000_1110, 1'b0, 32'h0);
        txn(1'b1, 30'h2000_4030, 4'b0000, 32'hFFFF_FFFF, 8'b0000_0001, 1'b0, 32'h0);
        b2b(30'h2000_4010, 30'h2000_4044, 4'b1001, 32'hA1B2_C3D4);
        txn(1'b0, 30'h2000_4044, 4'h0, 32'h0, 8'h00, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) a = (30'(base_m >> 2) & ~wmsk) | (30'($urandom) & wmsk);
            else a = 30'($urandom);
            txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 8'($urandom),
                1'($urandom_range(0, 4) == 0), cfgs[$urandom_range(0, 3)]);
        end

        write_cfg(32'h8001_0001);
        @(negedge gclk);
        req_vld = 2'b11; req_wr = 1'b1; req_addr = 30'h2000_4050; req_wmask = 4'hF;
        req_wdata = 32'h5A5A_A5A5;
        @(negedge gclk);
        req_vld = 2'b00; ram_stall = 1'b1;
        #1;
        chk("rstw_wrstr", 32'(o_wrstr[1]), 32'd1);
        @(negedge gclk);
        #2;
        chk("rstw_stall", 32'(o_stall[1]), 32'd1);
        greset_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        mem_wr(ram_word(30'h2000_4050), 4'hF, 32'h5A5A_A5A5);
        last_rd[0] = 32'h0; last_rd[1] = 32'h0; base_m = 32'h0;
        @(negedge gclk);
        greset_n = 1'b1; ram_stall = 1'b0;
        txn(1'b0, 30'h2000_4050, 4'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        write_cfg(32'h8001_0001);
        txn(1'b0, 30'h2000_4050, 4'h0, 32'h0, 8'h02, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
